// File: rtl/acia_6850.sv
// MC6850-style ACIA: bus-visible control/status/data registers, async serial tx/rx with /1,/16,/64 bit timing.
// Optional ACIA_LOOPBACK_EN adds a loopback input routing internal tx into the receiver.
module acia_6850 #(
   parameter int unsigned RX_SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       res,
   input  logic       clk_en,
   input  logic       cs,
   input  logic       rs,
   input  logic       rw,
   input  logic       e,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   input  logic       rx,
   output logic       tx,
   output logic       rts_n
`ifdef ACIA_LOOPBACK_EN
   ,
   input  logic       loopback
`endif
);

   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;

   tx_state_t tx_state, tx_next;
   rx_state_t rx_state, rx_next;

   logic [7:0] cr, tdr, rdr, tx_shift, rx_shift, rx_data;
   logic       tdre, rdrf, fe, ovrn, pe;
   logic       mr, brk, data8, par_en, par_odd, stop2;
   logic [5:0] div_max, half_max, tx_div, rx_div;
   logic [2:0] tx_cnt, rx_cnt;
   logic       tx_tick, tx_load, tx_par, tx_stop_cnt, tx_int;
   logic       rx_tick, rx_done, rx_par, rx_perr, rx_in, rx_s, rx_prev;
   logic       wr_cr, wr_dr, rd_dr;
   logic [RX_SYNC_STAGES-1:0] rx_sync;

   assign mr      = (cr[1:0] == 2'b11);
   assign brk     = (cr[6:5] == 2'b11);
   assign data8   = cr[4];
   assign par_en  = ~(cr[4] & ~cr[3]);
   assign par_odd = cr[2];
   assign stop2   = ~cr[3] & ~(cr[4] & cr[2]);

   always_comb begin
      div_max  = 6'd63;
      half_max = 6'd31;
      case (cr[1:0])
         2'b00:   begin div_max = 6'd0;  half_max = 6'd0; end
         2'b01:   begin div_max = 6'd15; half_max = 6'd7; end
         default: begin div_max = 6'd63; half_max = 6'd31; end
      endcase
   end

   assign wr_cr = cs & e & ~rw & ~rs;
   assign wr_dr = cs & e & ~rw & rs;
   assign rd_dr = cs & e & rw & rs;

   always_ff @(posedge clk or posedge res) begin
      if (res) cr <= 8'h03;
      else if (wr_cr) cr <= din;
   end

   // ---------------- transmitter ----------------
   always_ff @(posedge clk or posedge res) begin
      if (res) tx_div <= '0;
      else if (mr) tx_div <= '0;
      else if (clk_en) tx_div <= (tx_div >= div_max) ? '0 : tx_div + 6'd1;
   end

   assign tx_tick = clk_en & ~mr & (tx_div >= div_max);
   assign tx_load = tx_tick & ~brk & ~tdre & (tx_state == T_IDLE);

   always_ff @(posedge clk or posedge res) begin
      if (res) tx_state <= T_IDLE;
      else tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      if (mr || brk) tx_next = T_IDLE;
      else if (tx_tick) begin
         case (tx_state)
            T_IDLE:   if (!tdre) tx_next = T_START;
            T_START:  tx_next = T_DATA;
            T_DATA:   if (tx_cnt == (data8 ? 3'd7 : 3'd6)) tx_next = par_en ? T_PARITY : T_STOP;
            T_PARITY: tx_next = T_STOP;
            T_STOP:   if (!stop2 || tx_stop_cnt) tx_next = T_IDLE;
            default:  tx_next = T_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         tx_shift    <= '0;
         tx_cnt      <= '0;
         tx_par      <= 1'b0;
         tx_stop_cnt <= 1'b0;
      end else if (tx_load) begin
         tx_shift    <= tdr;
         tx_par      <= (^(data8 ? tdr : {1'b0, tdr[6:0]})) ^ par_odd;
         tx_cnt      <= '0;
         tx_stop_cnt <= 1'b0;
      end else if (tx_tick) begin
         if (tx_state == T_DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_cnt   <= tx_cnt + 3'd1;
         end
         if (tx_state == T_STOP) tx_stop_cnt <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         tdr  <= '0;
         tdre <= 1'b1;
      end else begin
         if (wr_dr) tdr <= din;
         // a write landing on the load cycle keeps TDRE low: the new byte is still pending
         if (mr) tdre <= 1'b1;
         else if (wr_dr) tdre <= 1'b0;
         else if (tx_load) tdre <= 1'b1;
      end
   end

   always_comb begin
      tx_int = 1'b1;
      case (tx_state)
         T_START:  tx_int = 1'b0;
         T_DATA:   tx_int = tx_shift[0];
         T_PARITY: tx_int = tx_par;
         default:  tx_int = 1'b1;
      endcase
      if (brk) tx_int = 1'b0;
      if (mr) tx_int = 1'b1;
   end

`ifdef ACIA_LOOPBACK_EN
   assign tx    = loopback ? 1'b1 : tx_int;
   assign rx_in = loopback ? tx_int : rx;
`else
   assign tx    = tx_int;
   assign rx_in = rx;
`endif

   assign rts_n = mr | (cr[6:5] == 2'b10);

   // ---------------- receiver ----------------
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         rx_sync <= '1;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[RX_SYNC_STAGES-2:0], rx_in};
         rx_prev <= rx_s;
      end
   end

   assign rx_s = rx_sync[RX_SYNC_STAGES-1];

   // START ticks at the half-bit point, later states at full-bit intervals from there
   assign rx_tick = clk_en & ((rx_state == R_START) ? (rx_div >= half_max) : (rx_div >= div_max));

   always_ff @(posedge clk or posedge res) begin
      if (res) rx_div <= '0;
      else if (rx_state == R_IDLE || rx_tick) rx_div <= '0;
      else if (clk_en) rx_div <= rx_div + 6'd1;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) rx_state <= R_IDLE;
      else rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      if (mr) rx_next = R_IDLE;
      else begin
         case (rx_state)
            R_IDLE:   if (rx_prev && !rx_s) rx_next = R_START;
            R_START:  if (rx_tick) rx_next = (rx_s && cr[1:0] != 2'b00) ? R_IDLE : R_DATA;
            R_DATA:   if (rx_tick && rx_cnt == (data8 ? 3'd7 : 3'd6)) rx_next = par_en ? R_PARITY : R_STOP;
            R_PARITY: if (rx_tick) rx_next = R_STOP;
            R_STOP:   if (rx_tick) rx_next = R_IDLE;
            default:  rx_next = R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         rx_shift <= '0;
         rx_cnt   <= '0;
         rx_par   <= 1'b0;
      end else if (rx_state == R_START) begin
         rx_cnt <= '0;
      end else if (rx_tick) begin
         if (rx_state == R_DATA) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_cnt   <= rx_cnt + 3'd1;
         end
         if (rx_state == R_PARITY) rx_par <= rx_s;
      end
   end

   assign rx_data = data8 ? rx_shift : {1'b0, rx_shift[7:1]};
   assign rx_perr = par_en & (rx_par != ((^rx_data) ^ par_odd));
   assign rx_done = rx_tick & ~mr & (rx_state == R_STOP);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         rdr  <= '0;
         rdrf <= 1'b0;
         fe   <= 1'b0;
         ovrn <= 1'b0;
         pe   <= 1'b0;
      end else if (mr) begin
         rdrf <= 1'b0;
         fe   <= 1'b0;
         ovrn <= 1'b0;
         pe   <= 1'b0;
      end else begin
         if (rd_dr) begin
            rdrf <= 1'b0;
            ovrn <= 1'b0;
         end
         // a data read in the completion cycle frees the buffer before the new byte lands
         if (rx_done) begin
            if (!rdrf || rd_dr) begin
               rdr  <= rx_data;
               rdrf <= 1'b1;
               fe   <= ~rx_s;
               pe   <= rx_perr;
            end else begin
               ovrn <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) irq <= 1'b0;
      else irq <= (cr[7] & (rdrf | ovrn)) | ((cr[6:5] == 2'b01) & tdre);
   end

   assign dout = rs ? rdr : {irq, pe, ovrn, fe, 2'b00, tdre, rdrf};

endmodule

// File: tb/tb_acia_6850.sv
// Scoreboard bench for acia_6850: bus-read and tx-frame monitors pop expected values queued by the stimulus.
module tb_acia_6850;

   logic       clk = 1'b0;
   logic       res, clk_en, cs, rs, rw, e, rx;
   logic [7:0] din, dout;
   logic       irq, tx, rts_n;
`ifdef ACIA_LOOPBACK_EN
   logic       loopback = 1'b0;
`endif

   acia_6850 #(.RX_SYNC_STAGES(2)) dut (
      .clk(clk), .res(res), .clk_en(clk_en), .cs(cs), .rs(rs), .rw(rw), .e(e),
      .din(din), .dout(dout), .irq(irq), .rx(rx), .tx(tx), .rts_n(rts_n)
`ifdef ACIA_LOOPBACK_EN
      , .loopback(loopback)
`endif
   );

   always #5 clk = ~clk;

   // one-cycle baud-base enable every second clk
   initial begin
      clk_en = 1'b0;
      forever begin
         @(negedge clk);
         clk_en = ~clk_en;
      end
   end

   typedef struct {
      string      name;
      logic [9:0] v;
   } exp_t;

   exp_t rd_q[$];
   exp_t tx_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   tx_mon_done;
   exp_t rd_item, tx_item;

   // bus monitor: every read cycle pops one expected value
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (cs && e && rw) begin
            total++;
            if (rd_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_read got=%02h want=none", dout);
            end else begin
               rd_item = rd_q.pop_front();
               if (dout !== rd_item.v[7:0]) begin
                  bad++;
                  $display("FAIL %s got=%02h want=%02h", rd_item.name, dout, rd_item.v[7:0]);
               end
            end
         end
      end
   end

   // tx monitor: captures one 10-bit frame per queued expectation, sampling mid-bit
   initial begin
      int n, ens;
      logic [9:0] bits;
      forever begin
         while (tx_q.size() == 0) @(posedge clk);
         n = 0;
         @(posedge clk); #1;
         while (tx !== 1'b0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
         end
         tx_item = tx_q.pop_front();
         total++;
         if (tx !== 1'b0) begin
            bad++;
            $display("FAIL %s got=no_start want=%03h", tx_item.name, tx_item.v);
         end else begin
            ens = 0;
            for (int k = 0; k < 10; k++) begin
               while (ens < 32 + 64 * k) begin
                  @(posedge clk); #1;
                  if (clk_en) ens++;
               end
               bits[k] = tx;
            end
            if (bits !== tx_item.v) begin
               bad++;
               $display("FAIL %s got=%03h want=%03h", tx_item.name, bits, tx_item.v);
            end
         end
         tx_mon_done = 1'b1;
      end
   end

   task automatic bus_write(input logic r, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; e = 1'b1; rw = 1'b0; rs = r; din = d;
      @(negedge clk);
      cs = 1'b0; e = 1'b0; rw = 1'b1;
   endtask

   task automatic read_reg(input string nm, input logic r, input logic [7:0] v);
      rd_q.push_back('{nm, {2'b00, v}});
      @(negedge clk);
      cs = 1'b1; e = 1'b1; rw = 1'b1; rs = r;
      @(negedge clk);
      cs = 1'b0; e = 1'b0;
   endtask

   task automatic check_pin(input string nm, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b", nm, got, want);
      end
   endtask

   task automatic wait_tx_low(input string nm);
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL %s got=timeout want=tx_low", nm);
      end
   endtask

   task automatic wait_mon(input string nm);
      int n;
      n = 0;
      while (!tx_mon_done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_mon_done) begin
         total++;
         bad++;
         $display("FAIL %s got=timeout want=frame_done", nm);
      end
   endtask

   // 64 enables per bit = 128 clks; LSB of b goes out first, then one idle bit
   task automatic send_bits(input logic [9:0] b);
      for (int i = 0; i < 10; i++) begin
         rx = b[i];
         repeat (128) @(negedge clk);
      end
      rx = 1'b1;
      repeat (128) @(negedge clk);
   endtask

   function automatic logic [9:0] f8n1(input logic [7:0] d, input logic stop_bit);
      return {stop_bit, d, 1'b0};
   endfunction

   initial begin
      res = 1'b1; cs = 1'b0; e = 1'b0; rw = 1'b1; rs = 1'b0; din = '0; rx = 1'b1;
      tx_mon_done = 1'b0;
      repeat (3) @(negedge clk);
      check_pin("reset_tx", tx, 1'b1);
      check_pin("reset_rts_n", rts_n, 1'b1);
      check_pin("reset_irq", irq, 1'b0);
      read_reg("reset_status", 1'b0, 8'h02);
      res = 1'b0;
      repeat (2) @(negedge clk);

      // /64, 8N1, rx irq on
      bus_write(1'b0, 8'h96);
      read_reg("cfg_status", 1'b0, 8'h02);
      @(negedge clk);
      check_pin("cfg_rts_n", rts_n, 1'b0);
      check_pin("cfg_irq", irq, 1'b0);

      // 5A on the wire: 0,0,1,0,1,1,0,1,0,1
      tx_mon_done = 1'b0;
      tx_q.push_back('{"tx_frame_5a", 10'h2B4});
      bus_write(1'b1, 8'h5A);
      wait_tx_low("tx_start_5a");
      bus_write(1'b1, 8'h33);
      read_reg("tdre_low_status", 1'b0, 8'h00);
      bus_write(1'b0, 8'hB6);
      repeat (2) @(negedge clk);
      check_pin("tx_irq_while_full", irq, 1'b0);
      check_pin("b6_rts_n", rts_n, 1'b0);
      wait_mon("tx_frame_5a_done");
      wait_tx_low("tx_start_33");
      repeat (2) @(negedge clk);
      check_pin("tx_irq_at_start", irq, 1'b1);
      read_reg("tdre_set_status", 1'b0, 8'h82);
      repeat (1500) @(negedge clk);
      bus_write(1'b0, 8'h96);
      repeat (2) @(negedge clk);
      check_pin("irq_off_96", irq, 1'b0);

      // receive F6
      send_bits(f8n1(8'hF6, 1'b1));
      check_pin("rx_f6_irq", irq, 1'b1);
      read_reg("rx_f6_status", 1'b0, 8'h83);
      read_reg("rx_f6_data", 1'b1, 8'hF6);
      read_reg("rx_f6_status_after", 1'b0, 8'h02);
      @(negedge clk);
      check_pin("rx_f6_irq_after", irq, 1'b0);

      // overrun
      send_bits(f8n1(8'h11, 1'b1));
      send_bits(f8n1(8'h22, 1'b1));
      read_reg("ovrn_status", 1'b0, 8'hA3);
      read_reg("ovrn_data", 1'b1, 8'h11);
      read_reg("ovrn_status_after", 1'b0, 8'h02);

      // 8'h8A decodes to 7E1: 41 has even ones, so parity bit 1 is wrong
      bus_write(1'b0, 8'h8A);
      send_bits({1'b1, 1'b1, 7'h41, 1'b0});
      read_reg("pe_7e1_status", 1'b0, 8'hC3);
      read_reg("pe_7e1_data", 1'b1, 8'h41);
      read_reg("pe_7e1_status_after", 1'b0, 8'h42);

      // 8'h8E decodes to word 011 = 7O1: correct parity would be 1
      bus_write(1'b0, 8'h8E);
      send_bits({1'b1, 1'b0, 7'h41, 1'b0});
      read_reg("pe_7o1_status", 1'b0, 8'hC3);
      read_reg("pe_7o1_data", 1'b1, 8'h41);
      read_reg("pe_7o1_status_after", 1'b0, 8'h42);

      // framing error, then a clean frame
      bus_write(1'b0, 8'h96);
      send_bits(f8n1(8'h3C, 1'b0));
      read_reg("fe_status", 1'b0, 8'h93);
      read_reg("fe_data", 1'b1, 8'h3C);
      read_reg("fe_status_after", 1'b0, 8'h12);
      send_bits(f8n1(8'hA5, 1'b1));
      read_reg("a5_status", 1'b0, 8'h83);
      read_reg("a5_data", 1'b1, 8'hA5);
      read_reg("a5_status_after", 1'b0, 8'h02);

      // 24-enable glitch is rejected at the half-bit check
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (1500) @(negedge clk);
      read_reg("glitch_status", 1'b0, 8'h02);

      // master reset mid-frame
      bus_write(1'b1, 8'h00);
      wait_tx_low("tx_start_00");
      repeat (300) @(negedge clk);
      check_pin("mid_frame_tx", tx, 1'b0);
      bus_write(1'b0, 8'h03);
      check_pin("mr_tx", tx, 1'b1);
      check_pin("mr_rts_n", rts_n, 1'b1);
      read_reg("mr_status", 1'b0, 8'h02);
      bus_write(1'b0, 8'h96);
      repeat (300) @(negedge clk);
      check_pin("after_mr_tx_idle", tx, 1'b1);

      // break forces tx low immediately
      bus_write(1'b0, 8'hF6);
      check_pin("break_tx", tx, 1'b0);
      bus_write(1'b0, 8'h96);
      check_pin("unbreak_tx", tx, 1'b1);

      repeat (4) @(negedge clk);
      if (rd_q.size() != 0 || tx_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover_expectations got=%0d want=0", rd_q.size() + tx_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
